motoro3_uart_cmd_rx: RTL and testbench

- Receive-side counterpart to the existing 19200-baud UART transmit path.
- Deserialises 8N1 bytes on rs232_rx and parses fixed 4-byte command frames.
- Drives registered m3start / m3invOrStop / m3freq to motoro3_top, so the motor can be commanded from a host instead of pins.
- Sits in the clk50mhz domain beside uartTop; the top muxes these outputs against pin inputs.

---
 rtl/motoro3_uart_cmd_rx.sv | 153 +++++++++++++++
 tb/tb_motoro3_uart_cmd_rx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro3_uart_cmd_rx.sv
// 8N1 UART receiver and 4-byte command frame parser for motoro3_top.
// Frame: SYNC, {start, invOrStop, rsvd[3:0], freq[9:8]}, freq[7:0], (byte1+byte2) mod 256.
module motoro3_uart_cmd_rx #(
    parameter int         CLKS_PER_BIT = 2604,
    parameter int         TIMEOUT_CLKS = 130000,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic       m3start,
    output logic       m3invOrStop,
    output logic [9:0] m3freq,
    output logic       cmd_valid,
    output logic       err_frame,
    output logic       err_cksum,
    output logic       rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
    typedef enum logic [1:0] {P_HUNT, P_B1, P_B2, P_CK} p_state_t;

    logic            rx_meta, rxs, rxs_prev, armed;
    logic [1:0]      fill;
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            bit_done, fall, byte_valid, frame_bad;

    p_state_t        p_state, p_next;
    logic [7:0]      b1, b2, ck_sum;
    logic [TW-1:0]   to_cnt;

    // armed only after a genuine high has been seen, so a line held low
    // through reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
            fill     <= 2'd0;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= rs232_rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
            if (fill != 2'd2) fill <= fill + 2'd1;
            if (fill == 2'd2 && rxs) armed <= 1'b1;
        end
    end

    assign fall       = armed && rxs_prev && !rxs;
    assign bit_done   = (cnt == BIT_LAST);
    assign byte_valid = (rx_state == RX_STOP) && bit_done && rxs;
    assign frame_bad  = (rx_state == RX_STOP) && bit_done && !rxs;
    assign rx_busy    = (rx_state != RX_IDLE);

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (fall) rx_next = RX_START;
            RX_START: if (cnt == HALF_LAST) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_done && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (bit_done) rx_next = rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rxs) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            err_frame <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            err_frame <= frame_bad;
            if (rx_next != rx_state || bit_done) cnt <= '0;
            else cnt <= cnt + 1'b1;
            if (rx_state == RX_START) bit_idx <= 3'd0;
            if (rx_state == RX_DATA && bit_done) begin
                shreg   <= {rxs, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign ck_sum = b1 + b2;

    // A bad stop bit or an inter-byte timeout abandons any partial frame.
    always_comb begin
        p_next = p_state;
        if (p_state != P_HUNT && frame_bad) begin
            p_next = P_HUNT;
        end else if (byte_valid) begin
            case (p_state)
                P_HUNT:  if (shreg == SYNC_BYTE) p_next = P_B1;
                P_B1:    p_next = P_B2;
                P_B2:    p_next = P_CK;
                default: p_next = P_HUNT;
            endcase
        end else if (p_state != P_HUNT && to_cnt == TO_LAST) begin
            p_next = P_HUNT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_state     <= P_HUNT;
            b1          <= 8'd0;
            b2          <= 8'd0;
            to_cnt      <= '0;
            m3start     <= 1'b0;
            m3invOrStop <= 1'b0;
            m3freq      <= 10'd0;
            cmd_valid   <= 1'b0;
            err_cksum   <= 1'b0;
        end else begin
            p_state   <= p_next;
            cmd_valid <= 1'b0;
            err_cksum <= 1'b0;
            if (p_state == P_HUNT || byte_valid) to_cnt <= '0;
            else to_cnt <= to_cnt + 1'b1;
            if (byte_valid) begin
                case (p_state)
                    P_B1: b1 <= shreg;
                    P_B2: b2 <= shreg;
                    P_CK: begin
                        if (shreg == ck_sum) begin
                            m3start     <= b1[7];
                            m3invOrStop <= b1[6];
                            m3freq      <= {b1[1:0], b2};
                            cmd_valid   <= 1'b1;
                        end else begin
                            err_cksum   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motoro3_uart_cmd_rx.sv
// Bench for motoro3_uart_cmd_rx: frame table, corner-case sequences and
// random frames checked against a byte-stream frame model.
module tb_motoro3_uart_cmd_rx;

    localparam int CPB     = 16;
    localparam int TIMEOUT = 800;
    localparam int W       = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232_rx = 1'b1;
    logic       m3start, m3invOrStop, cmd_valid, err_frame, err_cksum, rx_busy;
    logic [9:0] m3freq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_start_cyc = 0;
    int last_cmd_cyc   = 0;

    // Scoreboard entries: {kind[1:0], start, invOrStop, freq[9:0]}; kind 1=cmd 2=cksum 3=frame
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act_ev, exp_ev;

    // Reference model: frame buffer plus the last accepted command.
    logic [7:0] frm[$];
    logic       mdl_start = 1'b0;
    logic       mdl_inv   = 1'b0;
    logic [9:0] mdl_freq  = 10'd0;

    typedef struct {
        logic [31:0] bytes;
        logic        e_start;
        logic        e_inv;
        logic [9:0]  e_freq;
    } vec_t;
    vec_t vecs[5];

    motoro3_uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TIMEOUT), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .rs232_rx(rs232_rx),
        .m3start(m3start), .m3invOrStop(m3invOrStop), .m3freq(m3freq),
        .cmd_valid(cmd_valid), .err_frame(err_frame), .err_cksum(err_cksum),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(input logic [1:0] k);
        exp_q.push_back({k, mdl_start, mdl_inv, mdl_freq});
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (frm.size() == 0) begin
            if (b == 8'hA5) frm.push_back(b);
        end else begin
            frm.push_back(b);
            if (frm.size() == 4) begin
                if (8'((int'(frm[1]) + int'(frm[2])) % 256) == frm[3]) begin
                    mdl_start = frm[1][7];
                    mdl_inv   = frm[1][6];
                    mdl_freq  = {frm[1][1:0], frm[2]};
                    push_ev(2'd1);
                end else begin
                    push_ev(2'd2);
                end
                frm.delete();
            end
        end
    endfunction

    function automatic void model_frame_err();
        push_ev(2'd3);
        frm.delete();
    endfunction

    function automatic void model_reset();
        frm.delete();
        mdl_start = 1'b0;
        mdl_inv   = 1'b0;
        mdl_freq  = 10'd0;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int extra_low);
        if (stop_ok) model_byte(b);
        else model_frame_err();
        @(posedge clk);
        rs232_rx = 1'b0;
        last_start_cyc = cyc;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rs232_rx = stop_ok;
        repeat (CPB) @(posedge clk);
        if (!stop_ok) repeat (extra_low) @(posedge clk);
        rs232_rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_frame(input logic [31:0] f);
        for (int i = 0; i < 4; i++) send_byte(f[31-8*i -: 8], 1'b1, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        if (n >= TIMEOUT) frm.delete();
    endtask

    task automatic check_outs(input string name);
        @(negedge clk);
        check({name, "_start"}, 32'(m3start), 32'(mdl_start));
        check({name, "_inv"}, 32'(m3invOrStop), 32'(mdl_inv));
        check({name, "_freq"}, 32'(m3freq), 32'(mdl_freq));
    endtask

    // Every pulse must match the next event the model predicted.
    always @(negedge clk) begin
        if (!rst && (cmd_valid || err_cksum || err_frame)) begin
            act_ev = {(cmd_valid && !err_cksum && !err_frame) ? 2'd1 :
                      (err_cksum && !cmd_valid && !err_frame) ? 2'd2 :
                      (err_frame && !cmd_valid && !err_cksum) ? 2'd3 : 2'd0,
                      m3start, m3invOrStop, m3freq};
            if (cmd_valid) last_cmd_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_event: unexpected event got %h expected none", act_ev);
            end else begin
                exp_ev = exp_q.pop_front();
                if (act_ev !== exp_ev) begin
                    bad++;
                    $display("FAIL sb_event: got %h expected %h", act_ev, exp_ev);
                end
            end
        end
    end

    initial begin
        logic [7:0] r1, r2, rck;
        int mode, n;
        bit saw_busy;

        vecs[0] = '{32'hA5812CAD, 1'b1, 1'b0, 10'h12C};
        vecs[1] = '{32'hA5C3FFC2, 1'b1, 1'b1, 10'h3FF};
        vecs[2] = '{32'hA5812C00, 1'b1, 1'b1, 10'h3FF};
        vecs[3] = '{32'hA5000505, 1'b0, 1'b0, 10'h005};
        vecs[4] = '{32'hA57EA523, 1'b0, 1'b1, 10'h2A5};

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_start", 32'(m3start), 32'd0);
        check("rst_inv", 32'(m3invOrStop), 32'd0);
        check("rst_freq", 32'(m3freq), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_err_frame", 32'(err_frame), 32'd0);
        check("rst_err_cksum", 32'(err_cksum), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        @(posedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].bytes);
            @(negedge clk);
            check($sformatf("vec%0d_start", v), 32'(m3start), 32'(vecs[v].e_start));
            check($sformatf("vec%0d_inv", v), 32'(m3invOrStop), 32'(vecs[v].e_inv));
            check($sformatf("vec%0d_freq", v), 32'(m3freq), 32'(vecs[v].e_freq));
            if (v == 0) begin
                n = last_cmd_cyc - last_start_cyc;
                check("latency_in_stop_bit", 32'(n >= 9*CPB + 4 && n <= 10*CPB), 32'd1);
            end
        end

        // Bad stop bit, line held low, then a good frame.
        send_byte(8'h81, 1'b0, 40);
        send_frame(32'hA5812CAD);
        check_outs("after_break");

        // Mid-frame timeout: trailing bytes land in HUNT and are ignored.
        send_byte(8'hA5, 1'b1, 0);
        send_byte(8'h81, 1'b1, 0);
        idle(1000);
        send_byte(8'h2C, 1'b1, 0);
        send_byte(8'hAD, 1'b1, 0);
        check_outs("timeout_hold");
        send_frame(32'hA5C3FFC2);
        check_outs("after_timeout");

        // Short glitch on an idle line.
        saw_busy = 1'b0;
        @(posedge clk);
        rs232_rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            saw_busy |= rx_busy;
        end
        rs232_rx = 1'b1;
        n = 0;
        while (rx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("glitch_saw_busy", 32'(saw_busy), 32'd1);
        check("glitch_busy_clear", 32'(n <= 8), 32'd1);
        repeat (40) @(posedge clk);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'hFF, 1'b1, 0);
        send_frame(32'hA5000505);
        check_outs("after_garbage");
        check("garbage_freq", 32'(m3freq), 32'h005);

        // Reset mid-byte with the line held low.
        send_frame(32'hA5C3FFC2);
        send_byte(8'hA5, 1'b1, 0);
        @(posedge clk);
        rs232_rx = 1'b0;
        repeat (8) @(posedge clk);
        rst = 1'b1;
        model_reset();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("midrst_start", 32'(m3start), 32'd0);
        check("midrst_inv", 32'(m3invOrStop), 32'd0);
        check("midrst_freq", 32'(m3freq), 32'd0);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        @(posedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("low_after_rst_busy", 32'(rx_busy), 32'd0);
        @(posedge clk);
        rs232_rx = 1'b1;
        repeat (20) @(posedge clk);
        send_frame(32'hA5812CAD);
        check_outs("resend");

        // Random frames, some corrupted, aborted or preceded by garbage.
        for (int f = 0; f < 30; f++) begin
            r1  = 8'($urandom_range(0, 255));
            r2  = 8'($urandom_range(0, 255));
            rck = r1 + r2;
            if ($urandom_range(0, 3) == 0) rck = rck ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom_range(0, 255)), 1'b1, 0);
            send_byte(8'hA5, 1'b1, 0);
            mode = $urandom_range(0, 5);
            if (mode == 0) begin
                send_byte(r1, 1'b1, 0);
                idle(1000);
            end else if (mode == 1) begin
                send_byte(r1, 1'b0, $urandom_range(0, 20));
            end else begin
                send_byte(r1, 1'b1, 0);
                send_byte(r2, 1'b1, 0);
                send_byte(rck, 1'b1, 0);
            end
            check_outs($sformatf("rand%0d", f));
        end

        repeat (50) @(posedge clk);
        @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
